led_io_ctrl: RTL

LED_IO_CTRL -- requirements
Module: led_io_ctrl

---
 rtl/led_io_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/led_io_ctrl.sv
// LED IO controller: memory-mapped 24-bit LED display with a staged LO/HI
// commit, readback and an optional blink generator.
module led_io_ctrl #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        wr_ack,
    output logic [23:0] led
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        A_LO   = 2'b00,
        A_HI   = 2'b01,
        A_CTRL = 2'b10,
        A_RSV  = 2'b11
    } reg_addr_e;

    logic [15:0]   shadow_lo;
    logic [23:0]   disp;
    logic [3:0]    ctrl;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    phase;
    logic          blank;

    logic       blink_en;
    logic [2:0] rate;
    logic       tick;
    logic       wr_lo, wr_hi, wr_ctrl;

    assign blink_en = ctrl[0];
    assign rate     = ctrl[3:1];
    assign tick     = blink_en && (tick_cnt == TICK_LAST);
    assign wr_lo    = wr_en && (addr == A_LO);
    assign wr_hi    = wr_en && (addr == A_HI);
    assign wr_ctrl  = wr_en && (addr == A_CTRL);

    // Register file: LO stages the low halfword, HI commits all 24 bits at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_lo <= '0;
            disp      <= '0;
            ctrl      <= '0;
        end else begin
            if (wr_lo)   shadow_lo <= wr_data;
            if (wr_hi)   disp      <= {wr_data[7:0], shadow_lo};
            if (wr_ctrl) ctrl      <= wr_data[3:0];
        end
    end

    // Blink generator; a CTRL write restarts it and wins over a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            phase    <= '0;
            blank    <= 1'b0;
        end else if (wr_ctrl || !blink_en) begin
            tick_cnt <= '0;
            phase    <= '0;
            blank    <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                if (phase == rate) begin
                    phase <= '0;
                    blank <= ~blank;
                end else begin
                    phase <= phase + 3'd1;
                end
            end
        end
    end

    // Registered outputs: readback sees pre-write state, ack trails each write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            wr_ack  <= 1'b0;
            led     <= '0;
        end else begin
            wr_ack <= wr_en;
            led    <= (blink_en && blank) ? 24'h000000 : disp;
            if (rd_en) begin
                unique case (reg_addr_e'(addr))
                    A_LO:    rd_data <= shadow_lo;
                    A_HI:    rd_data <= {8'h00, disp[23:16]};
                    A_CTRL:  rd_data <= {12'h000, ctrl};
                    default: rd_data <= 16'h0000;
                endcase
            end
        end
    end

endmodule
